// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential fetch, flush/branch redirects,
// a one-entry pending branch held while fetch stalls, and target alignment.
//
// state | meaning
// IDLE  | after reset; ce=0, pc parked at RESET_VEC
// RUN   | fetching; pc advances on each granted request
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int                INST_BYTES = 4,
    parameter int                STALL_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   flush_target,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_target_address_i,
    input  logic                if_gnt,
    output logic [ADDR_W-1:0]   pc,
    output logic                ce,
    output logic                if_req,
    output logic                misalign_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic              pend_vld, pend_vld_nxt;
    logic              misalign_nxt;
    logic              advance;
    logic              unused_stall;

    // Only bit 0 of the stall vector holds fetch; the rest are ignored.
    assign unused_stall = ^stall;

    assign if_req  = ce & ~stall[0];
    assign advance = (state == RUN) & if_req & if_gnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_VEC;
            ce         <= 1'b0;
            misalign_o <= 1'b0;
            pend_addr  <= '0;
            pend_vld   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ce         <= (state_nxt == RUN);
            misalign_o <= misalign_nxt;
            pend_addr  <= pend_addr_nxt;
            pend_vld   <= pend_vld_nxt;
        end
    end

    // Redirect targets are aligned as they enter pc; misalign flags the
    // dropped low bits for the cycle after the redirect lands.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        pend_addr_nxt = pend_addr;
        pend_vld_nxt  = pend_vld;
        misalign_nxt  = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = RUN;
                pc_nxt    = RESET_VEC;
            end
            RUN: begin
                if (flush) begin
                    pc_nxt       = flush_target & ~LOW_MASK;
                    misalign_nxt = |(flush_target & LOW_MASK);
                    pend_vld_nxt = 1'b0;
                end else if (branch_flag_i && advance) begin
                    pc_nxt       = branch_target_address_i & ~LOW_MASK;
                    misalign_nxt = |(branch_target_address_i & LOW_MASK);
                    pend_vld_nxt = 1'b0;
                end else if (branch_flag_i) begin
                    pend_addr_nxt = branch_target_address_i;
                    pend_vld_nxt  = 1'b1;
                end else if (advance && pend_vld) begin
                    pc_nxt       = pend_addr & ~LOW_MASK;
                    misalign_nxt = |(pend_addr & LOW_MASK);
                    pend_vld_nxt = 1'b0;
                end else if (advance) begin
                    pc_nxt = pc + INC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, PC and target width in bits.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000 (ADDR_W bits), first fetch address after reset.
REQ-003 Parameter INST_BYTES, default 4, sequential increment; power of two, at least 1.
REQ-004 Parameter STALL_W, default 6, stall vector width; only bit 0 is used.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets.
REQ-007 stall  in  STALL_W  pipeline stall vector; stall[0]==1 holds fetch.
REQ-008 flush  in  1  exception or flush redirect request.
REQ-009 flush_target  in  ADDR_W  flush redirect address.
REQ-010 branch_flag_i  in  1  taken-branch pulse from ID.
REQ-011 branch_target_address_i  in  ADDR_W  branch target.
REQ-012 if_gnt  in  1  instruction memory accepts current request.
REQ-013 pc  out  ADDR_W  registered fetch address.
REQ-014 ce  out  1  registered chip enable to instruction memory.
REQ-015 if_req  out  1  fetch request, combinational: ce==1 and stall[0]==0.
REQ-016 misalign_o  out  1  registered one-cycle pulse: a taken target had nonzero low bits.

Function
REQ-017 FSM states: IDLE (ce=0) and RUN (ce=1); IDLE->RUN on the first edge with rst==1; RUN->IDLE only through reset.
REQ-018 pc SHALL hold RESET_VEC in IDLE; the first request after leaving IDLE SHALL be to RESET_VEC.
REQ-019 Advance condition: state RUN, if_req==1 and if_gnt==1 at the edge.
REQ-020 Next-pc priority, highest first: flush, branch_flag_i, pending redirect, pc+INST_BYTES.
REQ-021 flush==1 in RUN SHALL load flush_target at that edge, regardless of stall[0] or if_gnt, and clear any pending redirect.
REQ-022 branch_flag_i==1 on an advance edge SHALL load branch_target_address_i.
REQ-023 branch_flag_i==1 on a non-advance edge without flush SHALL capture the target into a one-entry pending register; a newer branch overwrites it.
REQ-024 A valid pending redirect SHALL be loaded into pc on the next advance edge and then cleared.
REQ-025 No advance, no flush: pc holds its value.
REQ-026 Sequential increment wraps modulo 2^ADDR_W.
REQ-027 Taken targets (flush, branch or pending) SHALL have their low log2(INST_BYTES) bits forced to zero.
REQ-028 When a forced bit was nonzero, misalign_o SHALL be 1 for exactly the following cycle.
REQ-029 flush or branch_flag_i in IDLE SHALL be ignored.
REQ-030 Simultaneous flush and branch_flag_i: flush wins; the branch is discarded, not made pending.

Reset
REQ-031 rst==0 at any edge, including mid-stall or mid-pending, SHALL force IDLE, pc=RESET_VEC, ce=0, misalign_o=0, pending cleared.
REQ-032 if_req SHALL be 0 throughout reset and IDLE.

Verification
REQ-033 Reset release, stall=0, if_gnt=1 -> ce=1 one edge after release; pc sequence 0x0, 0x4, 0x8, 0xC.
REQ-034 pc=0x10, if_gnt held 0 for 3 cycles -> pc stays 0x10; if_req stays 1; advances to 0x14 on first granted edge.
REQ-035 stall[0]=1 with branch_flag_i pulse, target 0x200, then stall released with grant -> pc=0x200 on first advance edge; pending cleared.
REQ-036 flush=1 (target 0x180) with branch_flag_i=1 (target 0x300) and stall[0]=1 -> pc=0x180 next edge; no later jump to 0x300.
REQ-037 ADDR_W=16, pc=0xFFFC, advance -> pc=0x0000; branch target 0x0103 -> pc=0x0100; misalign_o high one cycle.
REQ-038 Pending target 0x400 held, rst=0 for one edge -> pc=RESET_VEC, ce=0; after release, fetch resumes from RESET_VEC, never 0x400.
